// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   - Data and address widths, and the byte-access-pattern (amp) width.
//   - Default memory latency and starvation limit.
//   - FSM state encoding.
//   - Request latch layout: owner, write enable, amp, address, store data.
package mem_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam int AMP_W      = 4;

  localparam int MEM_LAT_DEF    = 2;  // legal range 1..7 (3-bit counter)
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  typedef struct packed {
    logic                 owner_d;  // 1: data port owns the access
    logic                 we;
    logic [AMP_W-1:0]     amp;
    logic [ADDR_SIZE-1:0] addr;
    logic [XLEN-1:0]      wdata;
  } req_latch_t;
endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// IDLE-state priority decision between fetch and data requests.
//   i_req, d_req : pending requests
//   scnt         : data grants issued so far while a fetch waited
//   gnt_i, gnt_d : one-hot (or none) grant decision
// Data wins by default; a fetch that has waited STARVE_MAX data grants wins.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic [2:0] scnt,
  output logic       gnt_i,
  output logic       gnt_d
);
  logic starved;

  assign starved = i_req && (scnt == 3'(STARVE_MAX));
  assign gnt_i   = i_req && (!d_req || starved);
  assign gnt_d   = d_req && !starved;
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between a fetch and a data port.
//   clk, reset       : clock, asynchronous active-low reset
//   i_req/i_addr     : fetch request; i_gnt, i_rvalid, i_rdata back
//   d_req/d_we/d_amp/d_addr/d_wdata : load/store request; d_gnt, d_rvalid, d_rdata back
//   m_*              : memory side; m_req pulses in the first busy cycle,
//                      the other m_* hold the latched request while busy
// Grants are combinational in IDLE; the access completes MEM_LAT cycles
// after the grant, and IDLE resumes the cycle after completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_SIZE-1:0]  i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [INSTR_SIZE-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [AMP_W-1:0]      d_amp,
  input  logic [ADDR_SIZE-1:0]  d_addr,
  input  logic [XLEN-1:0]       d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [XLEN-1:0]       d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [AMP_W-1:0]      m_amp,
  output logic [ADDR_SIZE-1:0]  m_addr,
  output logic [XLEN-1:0]       m_wdata,
  input  logic [XLEN-1:0]       m_rdata
);
  logic [1:0] state;
  logic [2:0] cnt;
  logic [2:0] scnt;
  req_latch_t lat;
  logic       busy, last, gnt_i, gnt_d;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .i_req (i_req),
    .d_req (d_req),
    .scnt  (scnt),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );

  // Grants are gated by reset so every output is 0 while reset is held,
  // even with a request pending.
  assign i_gnt = reset && (state == ST_IDLE) && gnt_i;
  assign d_gnt = reset && (state == ST_IDLE) && gnt_d;

  assign busy = (state != ST_IDLE);
  assign last = busy && (cnt == 3'd1);

  assign i_rvalid = last && !lat.owner_d;
  assign d_rvalid = last && lat.owner_d;
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = (d_rvalid && !lat.we) ? m_rdata : '0;

  // cnt is loaded with MEM_LAT, so the first busy cycle is cnt == MEM_LAT.
  assign m_req   = busy && (cnt == 3'(MEM_LAT));
  assign m_we    = busy && lat.owner_d && lat.we;
  assign m_amp   = busy ? lat.amp   : '0;
  assign m_addr  = busy ? lat.addr  : '0;
  assign m_wdata = busy ? lat.wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      scnt  <= '0;
      lat   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_gnt) begin
            // Fetches are whole-word reads.
            state       <= ST_BUSY_I;
            cnt         <= 3'(MEM_LAT);
            lat.owner_d <= 1'b0;
            lat.we      <= 1'b0;
            lat.amp     <= '1;
            lat.addr    <= i_addr;
            lat.wdata   <= '0;
          end else if (d_gnt) begin
            state       <= ST_BUSY_D;
            cnt         <= 3'(MEM_LAT);
            lat.owner_d <= 1'b1;
            lat.we      <= d_we;
            lat.amp     <= d_amp;
            lat.addr    <= d_addr;
            lat.wdata   <= d_wdata;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (i_gnt)
        scnt <= '0;
      else if (d_gnt && i_req && (scnt != 3'(STARVE_MAX)))
        scnt <= scnt + 3'd1;
    end
  end
endmodule
